// File: rtl/priority_bit_scanner_if.sv
// Handshake bundle for priority_bit_scanner: word input side and bit-beat output side.
// Latency: none (wires only).
// Backpressure: carries data_ready_o upstream and bit_ready_i from downstream.
//
// Signals:
//   data_val_i / data_ready_o / data_i / dir_i   word input handshake and payload
//   bit_val_o / bit_ready_i                      output beat handshake
//   bit_onehot_o / bit_idx_o / bit_last_o /
//   bit_remain_o / zero_o                        output beat payload
interface priority_bit_scanner_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
);
    logic             data_val_i;
    logic [WIDTH-1:0] data_i;
    logic             dir_i;
    logic             data_ready_o;
    logic             bit_val_o;
    logic             bit_ready_i;
    logic [WIDTH-1:0] bit_onehot_o;
    logic [IDX_W-1:0] bit_idx_o;
    logic             bit_last_o;
    logic [IDX_W:0]   bit_remain_o;
    logic             zero_o;

    // The scanner itself.
    modport slave (
        input  data_val_i, data_i, dir_i, bit_ready_i,
        output data_ready_o, bit_val_o, bit_onehot_o, bit_idx_o,
               bit_last_o, bit_remain_o, zero_o
    );

    // Whoever feeds words in and consumes beats.
    modport master (
        output data_val_i, data_i, dir_i, bit_ready_i,
        input  data_ready_o, bit_val_o, bit_onehot_o, bit_idx_o,
               bit_last_o, bit_remain_o, zero_o
    );
endinterface

// File: rtl/priority_bit_scanner.sv
// Accepts a word and emits one beat per set bit, LSB-first or MSB-first.
// Latency: first beat valid the cycle after word acceptance; one beat per cycle after that.
// Backpressure: bit_ready_i low freezes all state/outputs; data_ready_o only high when idle.
//
// Ports:
//   clk_i   clock, all state on rising edge
//   srst_i  synchronous active-high reset, overrides every handshake
//   bus     priority_bit_scanner_if.slave (word in, bit beats out)
module priority_bit_scanner #(
    parameter int WIDTH = 32,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    priority_bit_scanner_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [IDX_W:0] REMAIN_ONE = {{IDX_W{1'b0}}, 1'b1};

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] mask_q;
    logic             dir_q;
    logic [IDX_W:0]   remain_q;

    logic             in_scan;
    logic             accept;
    logic             beat_done;
    logic             last_beat;
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [WIDTH-1:0] sel_onehot;

    function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] cnt;
        cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {{IDX_W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    assign in_scan   = (state_q == SCAN);
    assign accept    = (state_q == IDLE) && bus.data_val_i;
    assign beat_done = in_scan && bus.bit_ready_i;
    // remain_q is 0 for an all-zero word, so its single beat is also the last one.
    assign last_beat = in_scan && (remain_q <= REMAIN_ONE);

    // Priority pick from the registered mask only. The loop order makes the
    // last match win: scanning downward leaves the lowest set bit, upward the highest.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (dir_q) begin
                if (mask_q[i]) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(i);
                end
            end else begin
                if (mask_q[WIDTH-1-i]) begin
                    sel_found = 1'b1;
                    sel_idx   = IDX_W'(WIDTH-1-i);
                end
            end
        end
    end

    always_comb begin
        sel_onehot = '0;
        if (sel_found) begin
            sel_onehot[sel_idx] = 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.data_val_i) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.bit_ready_i && last_beat) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            mask_q   <= '0;
            dir_q    <= 1'b0;
            remain_q <= '0;
        end else if (accept) begin
            mask_q   <= bus.data_i;
            dir_q    <= bus.dir_i;
            remain_q <= popcount(bus.data_i);
        end else if (beat_done) begin
            mask_q <= mask_q & ~sel_onehot;
            if (remain_q != '0) begin
                remain_q <= remain_q - REMAIN_ONE;
            end
        end
    end

    // Ready depends only on state and reset, never on bit_ready_i, so a word
    // finishing this cycle still leaves one idle cycle before the next word.
    assign bus.data_ready_o = (state_q == IDLE) && !srst_i;
    assign bus.bit_val_o    = in_scan;
    assign bus.bit_onehot_o = in_scan ? sel_onehot : '0;
    assign bus.bit_idx_o    = in_scan ? sel_idx : '0;
    assign bus.bit_last_o   = last_beat;
    assign bus.bit_remain_o = in_scan ? remain_q : '0;
    assign bus.zero_o       = in_scan && (remain_q == '0);

endmodule

// File: tb/tb_priority_bit_scanner.sv
module tb_priority_bit_scanner;

    localparam int W  = 8;
    localparam int IW = 3;

    logic clk;
    logic srst;

    priority_bit_scanner_if #(.WIDTH(W), .IDX_W(IW)) bus ();

    priority_bit_scanner #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: pending bit positions of the word in flight, in emit order.
    int q[$];
    bit busy      = 1'b0;
    bit zero_word = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [W-1:0] d, input logic dr);
        q.delete();
        if (dr) begin
            for (int i = W - 1; i >= 0; i--) if (d[i]) q.push_back(i);
        end else begin
            for (int i = 0; i < W; i++) if (d[i]) q.push_back(i);
        end
        busy      = 1'b1;
        zero_word = (d == '0);
    endtask

    task automatic check_model(input string tag);
        logic [W-1:0] e_oh;
        e_oh = '0;
        if (busy && !zero_word) e_oh[q[0]] = 1'b1;
        chk({tag, ".val"},    32'(bus.bit_val_o),    32'(busy));
        chk({tag, ".rdy"},    32'(bus.data_ready_o), 32'(!busy && !srst));
        chk({tag, ".onehot"}, 32'(bus.bit_onehot_o), 32'(e_oh));
        chk({tag, ".idx"},    32'(bus.bit_idx_o),    (busy && !zero_word) ? 32'(q[0]) : 32'd0);
        chk({tag, ".remain"}, 32'(bus.bit_remain_o), busy ? 32'(q.size()) : 32'd0);
        chk({tag, ".last"},   32'(bus.bit_last_o),   32'(busy && q.size() <= 1));
        chk({tag, ".zero"},   32'(bus.zero_o),       32'(busy && zero_word));
    endtask

    // Advance the model by the handshakes implied by the current inputs,
    // clock once, then compare the DUT against the model.
    task automatic cycle(input string tag);
        if (srst) begin
            busy = 1'b0;
            q.delete();
        end else if (!busy) begin
            if (bus.data_val_i) load_word(bus.data_i, bus.dir_i);
        end else if (bus.bit_ready_i) begin
            if (zero_word || q.size() <= 1) begin
                busy = 1'b0;
                q.delete();
            end else begin
                void'(q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic send(input logic [W-1:0] d, input logic dr, input string tag);
        bus.data_val_i = 1'b1;
        bus.data_i     = d;
        bus.dir_i      = dr;
        cycle(tag);
        bus.data_val_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int n = 0; n < 20 && busy; n++) cycle(tag);
        chk({tag, ".drained"}, 32'(busy), 32'd0);
    endtask

    initial begin
        srst            = 1'b1;
        bus.data_val_i  = 1'b0;
        bus.data_i      = '0;
        bus.dir_i       = 1'b0;
        bus.bit_ready_i = 1'b0;

        // Reset state, ready held low while reset asserted.
        cycle("rst0");
        cycle("rst1");
        srst = 1'b0;
        #1;
        chk("rst.rdy_after", 32'(bus.data_ready_o), 32'd1);

        // 8'hA4 LSB first.
        bus.bit_ready_i = 1'b1;
        send(8'hA4, 1'b0, "a4r.b1");
        chk("a4r.idx1", 32'(bus.bit_idx_o), 32'd2);
        chk("a4r.rem1", 32'(bus.bit_remain_o), 32'd3);
        cycle("a4r.b2");
        chk("a4r.oh2", 32'(bus.bit_onehot_o), 32'h20);
        cycle("a4r.b3");
        chk("a4r.idx3", 32'(bus.bit_idx_o), 32'd7);
        chk("a4r.last3", 32'(bus.bit_last_o), 32'd1);
        cycle("a4r.idle");
        chk("a4r.rdy", 32'(bus.data_ready_o), 32'd1);

        // Same word MSB first.
        send(8'hA4, 1'b1, "a4l.b1");
        chk("a4l.oh1", 32'(bus.bit_onehot_o), 32'h80);
        cycle("a4l.b2");
        cycle("a4l.b3");
        chk("a4l.oh3", 32'(bus.bit_onehot_o), 32'h04);
        chk("a4l.last3", 32'(bus.bit_last_o), 32'd1);
        cycle("a4l.idle");

        // All-zero word: one beat.
        send(8'h00, 1'b0, "zero.b");
        chk("zero.zero", 32'(bus.zero_o), 32'd1);
        chk("zero.last", 32'(bus.bit_last_o), 32'd1);
        cycle("zero.idle");
        chk("zero.rdy", 32'(bus.data_ready_o), 32'd1);

        // Stall for 3 cycles; dir/data/valid wiggle meanwhile must be ignored.
        bus.bit_ready_i = 1'b0;
        send(8'hA4, 1'b0, "stall.b1");
        for (int k = 0; k < 3; k++) begin
            bus.dir_i      = 1'b1;
            bus.data_val_i = 1'b1;
            bus.data_i     = 8'h3C;
            cycle("stall.hold");
            chk("stall.oh", 32'(bus.bit_onehot_o), 32'h04);
            chk("stall.rem", 32'(bus.bit_remain_o), 32'd3);
        end
        bus.data_val_i  = 1'b0;
        bus.bit_ready_i = 1'b1;
        drain("stall.resume");

        // Reset during the third beat of 8'hFF.
        send(8'hFF, 1'b0, "rstmid.b1");
        cycle("rstmid.b2");
        cycle("rstmid.b3");
        chk("rstmid.idx3", 32'(bus.bit_idx_o), 32'd2);
        srst = 1'b1;
        cycle("rstmid.rst");
        srst = 1'b0;
        #1;
        chk("rstmid.val", 32'(bus.bit_val_o), 32'd0);
        chk("rstmid.rdy", 32'(bus.data_ready_o), 32'd1);
        send(8'h01, 1'b0, "rstmid.w01");
        chk("rstmid.w01idx", 32'(bus.bit_idx_o), 32'd0);
        chk("rstmid.w01last", 32'(bus.bit_last_o), 32'd1);
        cycle("rstmid.idle");

        // All ones: 8 beats, first remain = WIDTH.
        send(8'hFF, 1'b0, "ff.b1");
        chk("ff.rem1", 32'(bus.bit_remain_o), 32'd8);
        for (int k = 1; k < 8; k++) cycle("ff.beat");
        chk("ff.idx8", 32'(bus.bit_idx_o), 32'd7);
        cycle("ff.idle");
        chk("ff.rdy", 32'(bus.data_ready_o), 32'd1);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            int kind;
            kind            = $urandom_range(0, 9);
            bus.data_val_i  = 1'($urandom_range(0, 1));
            bus.data_i      = (kind == 0) ? 8'h00 : (kind == 1) ? 8'hFF : 8'($urandom);
            bus.dir_i       = 1'($urandom_range(0, 1));
            bus.bit_ready_i = ($urandom_range(0, 3) != 0);
            srst            = ($urandom_range(0, 39) == 0);
            cycle("rand");
        end
        srst            = 1'b0;
        bus.data_val_i  = 1'b0;
        bus.bit_ready_i = 1'b1;
        drain("rand.end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/priority_bit_scanner.md
PRIORITY_BIT_SCANNER -- requirements
Module: priority_bit_scanner

Interface
REQ-001 Parameter WIDTH, default 32: input word width, >= 2.
REQ-002 Parameter IDX_W, default $clog2(WIDTH): width of the bit-index output.
REQ-003 Port clk_i, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port srst_i, input, 1: reset, synchronous and active-high.
REQ-005 Port data_val_i, input, 1: input word valid.
REQ-006 Port data_i, input, WIDTH: word to scan.
REQ-007 Port dir_i, input, 1: scan direction, sampled with data_i; 0 = LSB first (right), 1 = MSB first (left).
REQ-008 Port data_ready_o, output, 1: block can accept a word.
REQ-009 Port bit_val_o, output, 1: output beat valid.
REQ-010 Port bit_ready_i, input, 1: downstream accepts the beat.
REQ-011 Port bit_onehot_o, output, WIDTH: one-hot of the current selected set bit.
REQ-012 Port bit_idx_o, output, IDX_W: binary index of the current selected bit.
REQ-013 Port bit_last_o, output, 1: current beat is the final beat of the word.
REQ-014 Port bit_remain_o, output, IDX_W+1: set bits remaining, including the current beat.
REQ-015 Port zero_o, output, 1: the word being reported was all zeros.

Function
REQ-016 Input handshake: a word is accepted on a rising edge where data_val_i=1 and data_ready_o=1.
- data_i, dir_i and popcount(data_i) are latched into internal mask, direction and remaining-count registers.
REQ-017 The FSM has exactly two states, IDLE and SCAN.
- IDLE to SCAN on word acceptance.
- SCAN to IDLE on the handshake of the beat with bit_last_o=1.
REQ-018 data_ready_o = 1 only in IDLE with srst_i=0.
- One idle cycle always separates consecutive words; no combinational path exists from bit_ready_i to data_ready_o.
REQ-019 bit_val_o = 1 exactly when state is SCAN.
- The first beat is valid in the cycle after acceptance (latency 1).
REQ-020 In SCAN, bit_onehot_o is derived from the mask register only:
- dir=0: lowest set bit of the mask.
- dir=1: highest set bit of the mask.
- bit_idx_o is its binary position.
REQ-021 Output beat handshake: a beat completes on a rising edge where bit_val_o=1 and bit_ready_i=1.
- The reported bit is cleared from the mask.
- bit_remain_o decrements by 1.
REQ-022 Under bit_ready_i=1 the block issues one beat per cycle; a word with N set bits occupies N consecutive cycles.
REQ-023 While bit_val_o=1 and bit_ready_i=0, all bit_* outputs, zero_o and internal state hold unchanged.
REQ-024 bit_last_o = 1 when bit_remain_o <= 1 in SCAN.
REQ-025 An all-zero word produces exactly one beat:
- bit_onehot_o=0, bit_idx_o=0, bit_remain_o=0, bit_last_o=1, zero_o=1.
REQ-026 zero_o = 0 for any word with at least one set bit.
REQ-027 In IDLE:
- bit_onehot_o, bit_idx_o, bit_remain_o, bit_last_o and zero_o are 0.
- data_val_i while not ready is ignored, and no word is lost from the block's side.
REQ-028 For an all-ones word, bit_remain_o on the first beat equals WIDTH; IDX_W+1 bits are sufficient for this.
REQ-029 dir_i changes during SCAN do not affect the word in progress.
REQ-030 No combinational path exists from data_i, dir_i or data_val_i to any bit_* output.

Reset
REQ-031 On a rising edge with srst_i=1, the block enters IDLE and clears mask, direction and count registers; reset takes priority over all handshakes.
REQ-032 After reset, outputs read: bit_val_o=0, bit_onehot_o=0, bit_idx_o=0, bit_remain_o=0, bit_last_o=0, zero_o=0, and data_ready_o=0 while srst_i=1.
REQ-033 Reset asserted mid-SCAN discards the word in progress.
- No further beats of that word are emitted.
- The next accepted word scans from its own data only.

Verification
REQ-034 WIDTH=8, data_i=8'hA4, dir_i=0, bit_ready_i=1 -> three beats in consecutive cycles:
- onehot 8'h04 / 8'h20 / 8'h80.
- idx 2 / 5 / 7.
- remain 3 / 2 / 1.
- last on third beat only.
REQ-035 Same word with dir_i=1 -> three beats:
- onehot 8'h80 / 8'h20 / 8'h04.
- idx 7 / 5 / 2.
- last on 8'h04.
REQ-036 data_i=0 -> single beat: onehot 0, zero_o=1, last=1, remain 0; then IDLE and data_ready_o=1 the next cycle.
REQ-037 8'hA4, dir_i=0, bit_ready_i held 0 for 3 cycles after the first valid -> onehot 8'h04 and remain 3 stable for all 3 cycles; scan resumes when bit_ready_i=1.
REQ-038 8'hFF accepted, srst_i pulsed during the third beat -> next cycle bit_val_o=0 and data_ready_o=1; a subsequent 8'h01 yields one beat with idx 0, last=1.
REQ-039 8'hFF with bit_ready_i=1 -> 8 beats, idx 0..7 with dir_i=0, first remain=8; data_ready_o returns to 1 one cycle after the eighth beat.
